// File: rtl/decode_queue_pkg.sv
// Shared decode encodings for decode_queue: op groups, fixed op codes, widths.
// orderType layout is {group[2:0], alt, funct3}; fixed ops use the U/J group.
package decode_queue_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_INST_WIDTH = 32;
  localparam int unsigned REG_WIDTH      = 5;
  localparam int unsigned VAL_WIDTH      = 32;
  localparam int unsigned OP_WIDTH       = 7;

  typedef enum logic [2:0] {
    OP_U_J_TYPE = 3'd0,
    OP_I_TYPE   = 3'd1,
    OP_R_TYPE   = 3'd2,
    OP_L_TYPE   = 3'd3,
    OP_S_TYPE   = 3'd4,
    OP_B_TYPE   = 3'd5,
    OP_X_TYPE   = 3'd7
  } op_group_e;

  localparam logic [OP_WIDTH-1:0] OP_LUI     = 7'h00;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC   = 7'h01;
  localparam logic [OP_WIDTH-1:0] OP_JAL     = 7'h02;
  localparam logic [OP_WIDTH-1:0] OP_JALR    = 7'h03;
  localparam logic [OP_WIDTH-1:0] OP_ILLEGAL = 7'h7F;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic op_is_mem(input logic [OP_WIDTH-1:0] op);
    return (op[6:4] == OP_L_TYPE) || (op[6:4] == OP_S_TYPE);
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side signal bundle for decode_queue.
// slave = decode_queue view, master = fetch/backend view.
interface decode_queue_if #(
  parameter int unsigned ADDR_WIDTH = decode_queue_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = decode_queue_pkg::DEF_INST_WIDTH
);

  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  if_pred;
  logic                  dec_ready;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic                  lsbFull;
  logic                  rsFull;
  logic                  robFull;
  logic                  dec_valid;
  logic [6:0]            orderType;
  logic [4:0]            dec_rd;
  logic [4:0]            dec_rs1;
  logic [4:0]            dec_rs2;
  logic [31:0]           dec_imm;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic                  dec_pred;
  logic                  dec2lsb_en;
  logic                  dec2rs_en;
  logic                  dec2rob_en;

  modport slave (
    input  if_valid, if_pc, if_inst, if_pred, lsbFull, rsFull, robFull,
    output dec_ready, redirect, redirect_pc, dec_valid, orderType,
           dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc, dec_pred,
           dec2lsb_en, dec2rs_en, dec2rob_en
  );

  modport master (
    output if_valid, if_pc, if_inst, if_pred, lsbFull, rsFull, robFull,
    input  dec_ready, redirect, redirect_pc, dec_valid, orderType,
           dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc, dec_pred,
           dec2lsb_en, dec2rs_en, dec2rob_en
  );

endinterface

// File: rtl/decode_queue_rv32_decode_comb.sv
// Combinational RV32I field decoder: inst -> {orderType, rd, rs1, rs2, imm}.
// Define DEC_ILLEGAL_CHECK_EN to map bad encodings onto OP_ILLEGAL.
module rv32_decode_comb
  import decode_queue_pkg::*;
(
  input  logic [31:0]          inst,
  output logic [OP_WIDTH-1:0]  order_type,
  output logic [REG_WIDTH-1:0] rd,
  output logic [REG_WIDTH-1:0] rs1,
  output logic [REG_WIDTH-1:0] rs2,
  output logic [VAL_WIDTH-1:0] imm
);

  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [OP_WIDTH-1:0]  raw_op;
  logic [REG_WIDTH-1:0] raw_rd, raw_rs1, raw_rs2;
  logic [VAL_WIDTH-1:0] raw_imm;
  logic [31:0]          i_imm, s_imm, b_imm, u_imm, j_imm;
  logic                 alt_rr;

  always_comb begin
    opcode = inst[6:0];
    f3     = inst[14:12];
    i_imm  = {{20{inst[31]}}, inst[31:20]};
    s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm  = {inst[31:12], 12'b0};
    j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    alt_rr = inst[30] && ((f3 == 3'd0) || (f3 == 3'd5));

    raw_op  = '0;
    raw_rd  = '0;
    raw_rs1 = '0;
    raw_rs2 = '0;
    raw_imm = '0;

    case (opcode)
      OPC_LUI:   begin raw_op = OP_LUI;   raw_rd = inst[11:7]; raw_imm = u_imm; end
      OPC_AUIPC: begin raw_op = OP_AUIPC; raw_rd = inst[11:7]; raw_imm = u_imm; end
      OPC_JAL:   begin raw_op = OP_JAL;   raw_rd = inst[11:7]; raw_imm = j_imm; end
      OPC_JALR: begin
        raw_op  = OP_JALR;
        raw_rd  = inst[11:7];
        raw_rs1 = inst[19:15];
        raw_imm = i_imm;
      end
      OPC_LOAD: begin
        raw_op  = {OP_L_TYPE, 1'b0, f3};
        raw_rd  = inst[11:7];
        raw_rs1 = inst[19:15];
        raw_imm = i_imm;
      end
      OPC_STORE: begin
        raw_op  = {OP_S_TYPE, 1'b0, f3};
        raw_rs1 = inst[19:15];
        raw_rs2 = inst[24:20];
        raw_imm = s_imm;
      end
      OPC_BRANCH: begin
        raw_op  = {OP_B_TYPE, 1'b0, f3};
        raw_rs1 = inst[19:15];
        raw_rs2 = inst[24:20];
        raw_imm = b_imm;
      end
      OPC_OP_IMM: begin
        raw_rd  = inst[11:7];
        raw_rs1 = inst[19:15];
        // shift amounts are zero-extended; sltiu keeps the sign-extended form
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          raw_op  = {OP_I_TYPE, inst[30], f3};
          raw_imm = {27'b0, inst[24:20]};
        end else begin
          raw_op  = {OP_I_TYPE, 1'b0, f3};
          raw_imm = i_imm;
        end
      end
      OPC_OP: begin
        raw_op  = {OP_R_TYPE, alt_rr, f3};
        raw_rd  = inst[11:7];
        raw_rs1 = inst[19:15];
        raw_rs2 = inst[24:20];
      end
      default: begin
        raw_op  = opcode;
        raw_rd  = inst[11:7];
        raw_rs1 = inst[19:15];
        raw_rs2 = inst[24:20];
        raw_imm = i_imm;
      end
    endcase
  end

`ifdef DEC_ILLEGAL_CHECK_EN
  logic [6:0] f7;
  logic       bad;

  always_comb begin
    f7  = inst[31:25];
    bad = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: bad = 1'b0;
      OPC_JALR:   bad = (f3 != 3'd0);
      OPC_LOAD:   bad = (f3 == 3'd3) || (f3 >= 3'd6);
      OPC_STORE:  bad = (f3 > 3'd2);
      OPC_BRANCH: bad = (f3 == 3'd2) || (f3 == 3'd3);
      OPC_OP_IMM: begin
        if (f3 == 3'd1)      bad = (f7 != 7'h00);
        else if (f3 == 3'd5) bad = (f7 != 7'h00) && (f7 != 7'h20);
        else                 bad = 1'b0;
      end
      OPC_OP: bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      default: bad = 1'b1;
    endcase

    order_type = raw_op;
    rd         = raw_rd;
    rs1        = raw_rs1;
    rs2        = raw_rs2;
    imm        = raw_imm;
    if (bad) begin
      order_type = OP_ILLEGAL;
      rd         = '0;
      rs1        = '0;
      rs2        = '0;
      imm        = '0;
    end
  end
`else
  assign order_type = raw_op;
  assign rd         = raw_rd;
  assign rs1        = raw_rs1;
  assign rs2        = raw_rs2;
  assign imm        = raw_imm;
`endif

endmodule

// File: rtl/decode_queue.sv
// DEPTH-entry fetch queue feeding a registered RV32I decode/dispatch stage,
// with fetch redirect for JAL and predicted-taken branches. Optional: DEC_ILLEGAL_CHECK_EN.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = DEF_INST_WIDTH
) (
  input logic           clk,
  input logic           rst_n_in,
  input logic           rdy_in,
  input logic           flush,
  decode_queue_if.slave dq
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
  logic [DEPTH-1:0]      pred_mem_q, pred_mem_d;

  logic                  dec_valid_q, dec_valid_d;
  logic [OP_WIDTH-1:0]   order_type_q, order_type_d;
  logic [REG_WIDTH-1:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [VAL_WIDTH-1:0]  imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pred_q, pred_d;
  logic                  redirect_q, redirect_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0]      head_idx, tail_idx;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0] head_inst;
  logic                  head_pred;
  logic [OP_WIDTH-1:0]   dc_op;
  logic [REG_WIDTH-1:0]  dc_rd, dc_rs1, dc_rs2;
  logic [VAL_WIDTH-1:0]  dc_imm;
  logic                  empty, full, is_mem, fire, load, push, take_redirect;

  rv32_decode_comb u_decode (
    .inst       (head_inst),
    .order_type (dc_op),
    .rd         (dc_rd),
    .rs1        (dc_rs1),
    .rs2        (dc_rs2),
    .imm        (dc_imm)
  );

  always_comb begin
    head_idx  = rd_ptr_q[IDX_W-1:0];
    tail_idx  = wr_ptr_q[IDX_W-1:0];
    head_pc   = pc_mem_q[head_idx];
    head_inst = inst_mem_q[head_idx];
    head_pred = pred_mem_q[head_idx];

    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
             (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    is_mem = op_is_mem(order_type_q);
    // gated by rdy_in so a frozen cycle never reports a dispatch it will not retire
    fire   = rdy_in && dec_valid_q && !dq.robFull && (is_mem ? !dq.lsbFull : !dq.rsFull);
    load   = !empty && (!dec_valid_q || fire);
    push   = dq.if_valid && !full;
    take_redirect = load && ((dc_op == OP_JAL) || ((dc_op[6:4] == OP_B_TYPE) && head_pred));
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pc_mem_d      = pc_mem_q;
    inst_mem_d    = inst_mem_q;
    pred_mem_d    = pred_mem_q;
    dec_valid_d   = dec_valid_q;
    order_type_d  = order_type_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    pred_d        = pred_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;

    if (rdy_in) begin
      redirect_d = 1'b0;
      if (flush) begin
        rd_ptr_d    = wr_ptr_q;
        dec_valid_d = 1'b0;
      end else begin
        if (load) begin
          dec_valid_d  = 1'b1;
          order_type_d = dc_op;
          rd_d         = dc_rd;
          rs1_d        = dc_rs1;
          rs2_d        = dc_rs2;
          imm_d        = dc_imm;
          pc_d         = head_pc;
          pred_d       = head_pred;
        end else if (fire) begin
          dec_valid_d = 1'b0;
        end

        // a redirect pops the head and drops every younger entry plus this cycle's fetch
        if (take_redirect) begin
          rd_ptr_d      = wr_ptr_q;
          redirect_d    = 1'b1;
          redirect_pc_d = head_pc + ADDR_WIDTH'(dc_imm);
        end else begin
          if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (push) begin
            pc_mem_d[tail_idx]   = dq.if_pc;
            inst_mem_d[tail_idx] = dq.if_inst;
            pred_mem_d[tail_idx] = dq.if_pred;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      pred_mem_q    <= '0;
      dec_valid_q   <= 1'b0;
      order_type_q  <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      pred_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
      pred_mem_q    <= pred_mem_d;
      dec_valid_q   <= dec_valid_d;
      order_type_q  <= order_type_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      pred_q        <= pred_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign dq.dec_ready   = !full;
  assign dq.redirect    = redirect_q;
  assign dq.redirect_pc = redirect_pc_q;
  assign dq.dec_valid   = dec_valid_q;
  assign dq.orderType   = order_type_q;
  assign dq.dec_rd      = rd_q;
  assign dq.dec_rs1     = rs1_q;
  assign dq.dec_rs2     = rs2_q;
  assign dq.dec_imm     = imm_q;
  assign dq.dec_pc      = pc_q;
  assign dq.dec_pred    = pred_q;
  assign dq.dec2lsb_en  = fire && is_mem;
  assign dq.dec2rs_en   = fire && !is_mem;
  assign dq.dec2rob_en  = fire;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, default build).
module tb_decode_queue;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;
  int   n_cmp;
  int   n_err;

  decode_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dq ();

  decode_queue #(.DEPTH(4), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .flush    (flush),
    .dq       (dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
    dq.if_valid = 1'b1;
    dq.if_pc    = pc;
    dq.if_inst  = inst;
    dq.if_pred  = pred;
  endtask

  task automatic idle();
    dq.if_valid = 1'b0;
    dq.if_pred  = 1'b0;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] n);
    return ({27'b0, n} << 20) | ({27'b0, n} << 7) | 32'h13;
  endfunction

  // lui x6 / srai x3,x4,5 / sub x7,x8,x9 / sw x5,12(x2) / sltiu x1,x2,-1
  logic [31:0] v_inst [5] = '{32'h12345337, 32'h40525193, 32'h409403B3, 32'h00512623, 32'hFFF13093};
  logic [31:0] v_op   [5] = '{32'h00, 32'h1D, 32'h28, 32'h42, 32'h13};
  logic [31:0] v_rd   [5] = '{32'd6, 32'd3, 32'd7, 32'd0, 32'd1};
  logic [31:0] v_rs1  [5] = '{32'd0, 32'd4, 32'd8, 32'd2, 32'd2};
  logic [31:0] v_rs2  [5] = '{32'd0, 32'd0, 32'd9, 32'd5, 32'd0};
  logic [31:0] v_imm  [5] = '{32'h12345000, 32'd5, 32'd0, 32'd12, 32'hFFFFFFFF};
  logic [31:0] v_mem  [5] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rdy   = 1'b1;
    flush = 1'b0;
    dq.lsbFull = 1'b0;
    dq.rsFull  = 1'b0;
    dq.robFull = 1'b0;
    dq.if_pc   = '0;
    dq.if_inst = '0;
    idle();
    tick();
    tick();
    check("rst_dec_ready", 32'(dq.dec_ready), 32'd1);
    check("rst_dec_valid", 32'(dq.dec_valid), 32'd0);
    check("rst_redirect", 32'(dq.redirect), 32'd0);
    check("rst_redirect_pc", dq.redirect_pc, 32'd0);
    check("rst_orderType", 32'(dq.orderType), 32'd0);
    check("rst_dec_pc", dq.dec_pc, 32'd0);
    check("rst_rob_en", 32'(dq.dec2rob_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back decode of assorted formats, one dispatched per cycle
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) offer(32'h200 + 32'(i) * 4, v_inst[i], 1'b0);
      else       idle();
      tick();
      if (i >= 1) begin
        check($sformatf("vec%0d_valid", i-1), 32'(dq.dec_valid), 32'd1);
        check($sformatf("vec%0d_op", i-1), 32'(dq.orderType), v_op[i-1]);
        check($sformatf("vec%0d_rd", i-1), 32'(dq.dec_rd), v_rd[i-1]);
        check($sformatf("vec%0d_rs1", i-1), 32'(dq.dec_rs1), v_rs1[i-1]);
        check($sformatf("vec%0d_rs2", i-1), 32'(dq.dec_rs2), v_rs2[i-1]);
        check($sformatf("vec%0d_imm", i-1), dq.dec_imm, v_imm[i-1]);
        check($sformatf("vec%0d_pc", i-1), dq.dec_pc, 32'h200 + 32'(i-1) * 4);
        check($sformatf("vec%0d_lsb_en", i-1), 32'(dq.dec2lsb_en), v_mem[i-1]);
        check($sformatf("vec%0d_rob_en", i-1), 32'(dq.dec2rob_en), 32'd1);
      end
    end
    tick();
    check("vec_drain_valid", 32'(dq.dec_valid), 32'd0);

    // backend routing: lw waits on lsbFull only
    dq.lsbFull = 1'b1;
    offer(32'h80, 32'h00812283, 1'b0);
    tick();
    idle();
    tick();
    check("lw_valid", 32'(dq.dec_valid), 32'd1);
    check("lw_stall_lsb_en", 32'(dq.dec2lsb_en), 32'd0);
    check("lw_stall_rob_en", 32'(dq.dec2rob_en), 32'd0);
    tick();
    check("lw_held_valid", 32'(dq.dec_valid), 32'd1);
    dq.lsbFull = 1'b0;
    #1;
    check("lw_lsb_en", 32'(dq.dec2lsb_en), 32'd1);
    check("lw_rs_en", 32'(dq.dec2rs_en), 32'd0);
    check("lw_imm", dq.dec_imm, 32'd8);
    check("lw_rs1", 32'(dq.dec_rs1), 32'd2);
    check("lw_rd", 32'(dq.dec_rd), 32'd5);
    check("lw_op", 32'(dq.orderType), 32'h32);
    check("lw_pc", dq.dec_pc, 32'h80);
    tick();
    check("lw_done_valid", 32'(dq.dec_valid), 32'd0);

    // fill: 4 queued + 1 held in the output stage, 6th push dropped
    dq.robFull = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(32'(i) * 4, addi(5'(i)), 1'b0);
      tick();
      if (i == 4) check("fill4_ready", 32'(dq.dec_ready), 32'd1);
    end
    check("fill5_ready", 32'(dq.dec_ready), 32'd0);
    check("fill5_valid", 32'(dq.dec_valid), 32'd1);
    check("fill5_rd", 32'(dq.dec_rd), 32'd1);
    offer(32'd24, addi(5'd6), 1'b0);
    tick();
    check("fill6_ready", 32'(dq.dec_ready), 32'd0);
    idle();
    dq.robFull = 1'b0;
    #1;
    check("fill_fire1_rs_en", 32'(dq.dec2rs_en), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("fill_fire%0d_rd", k), 32'(dq.dec_rd), 32'(k));
      check($sformatf("fill_fire%0d_en", k), 32'(dq.dec2rob_en), 32'd1);
    end
    tick();
    check("fill_drop6_valid", 32'(dq.dec_valid), 32'd0);
    check("fill_drain_ready", 32'(dq.dec_ready), 32'd1);

    // JAL redirect discards younger entries and the same-cycle fetch
    dq.robFull = 1'b1;
    offer(32'hFC, addi(5'd7), 1'b0);
    tick();
    offer(32'h100, 32'h020000EF, 1'b0);
    tick();
    offer(32'h104, addi(5'd8), 1'b0);
    tick();
    offer(32'h108, addi(5'd9), 1'b0);
    tick();
    offer(32'h10C, addi(5'd10), 1'b0);
    dq.robFull = 1'b0;
    tick();
    idle();
    check("jal_redirect", 32'(dq.redirect), 32'd1);
    check("jal_redirect_pc", dq.redirect_pc, 32'h120);
    check("jal_pc", dq.dec_pc, 32'h100);
    check("jal_imm", dq.dec_imm, 32'h20);
    check("jal_rd", 32'(dq.dec_rd), 32'd1);
    check("jal_op", 32'(dq.orderType), 32'h02);
    tick();
    check("jal_pulse_end", 32'(dq.redirect), 32'd0);
    check("jal_discard_valid", 32'(dq.dec_valid), 32'd0);
    tick();
    check("jal_discard_valid2", 32'(dq.dec_valid), 32'd0);

    // branches: not-taken prediction never redirects
    offer(32'h30, 32'h00208463, 1'b0);
    tick();
    idle();
    tick();
    check("beq_valid", 32'(dq.dec_valid), 32'd1);
    check("beq_redirect", 32'(dq.redirect), 32'd0);
    check("beq_imm", dq.dec_imm, 32'd8);
    tick();
    offer(32'h40, 32'hFE209CE3, 1'b1);
    tick();
    idle();
    tick();
    check("bne_redirect", 32'(dq.redirect), 32'd1);
    check("bne_redirect_pc", dq.redirect_pc, 32'h38);
    check("bne_imm", dq.dec_imm, 32'hFFFFFFF8);
    check("bne_pred", 32'(dq.dec_pred), 32'd1);
    tick();
    check("bne_pulse_end", 32'(dq.redirect), 32'd0);

    // flush: ignored while rdy_in=0, then empties queue and output stage
    dq.robFull = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'h300 + 32'(i) * 4, addi(5'(i)), 1'b0);
      tick();
    end
    idle();
    rdy   = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_frozen_valid", 32'(dq.dec_valid), 32'd1);
    check("flush_frozen_rd", 32'(dq.dec_rd), 32'd1);
    rdy = 1'b1;
    offer(32'h320, addi(5'd9), 1'b0);
    tick();
    flush = 1'b0;
    idle();
    check("flush_valid", 32'(dq.dec_valid), 32'd0);
    check("flush_ready", 32'(dq.dec_ready), 32'd1);
    check("flush_redirect", 32'(dq.redirect), 32'd0);
    dq.robFull = 1'b0;
    tick();
    check("flush_empty_valid", 32'(dq.dec_valid), 32'd0);
    tick();
    check("flush_empty_valid2", 32'(dq.dec_valid), 32'd0);

    // asynchronous reset mid-burst, with the queue full
    dq.robFull = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(32'h400 + 32'(i) * 4, addi(5'(i)), 1'b0);
      tick();
    end
    check("prerst_ready", 32'(dq.dec_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(dq.dec_valid), 32'd0);
    check("arst_ready", 32'(dq.dec_ready), 32'd1);
    check("arst_rd", 32'(dq.dec_rd), 32'd0);
    idle();
    dq.robFull = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_valid", 32'(dq.dec_valid), 32'd0);
    tick();
    check("postrst_valid2", 32'(dq.dec_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register decode stage; sits between ifetch and the dispatch targets (rs / lsb / rob).
- A DEPTH-entry instruction queue absorbs fetch bursts.
- Decodes RV32I from the queue head into a registered output stage, held until the proper backend has room.
- Redirects fetch for JAL and for predicted-taken branches, and squashes wrong-path entries internally.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- ADDR_WIDTH, 32, pc width.
- INST_WIDTH, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes all state.
- flush  in  1  synchronous squash from rob (mispredict).
- if_valid  in  1  fetch offers an instruction.
- if_pc  in  ADDR_WIDTH  pc of the offered instruction.
- if_inst  in  INST_WIDTH  instruction word.
- if_pred  in  1  predictor taken bit.
- dec_ready  out  1  queue not full; fetch may push.
- redirect  out  1  one-cycle pulse: fetch restarts at redirect_pc.
- redirect_pc  out  ADDR_WIDTH  redirect target.
- lsbFull, rsFull, robFull  in  1 each  backend full flags.
- dec_valid  out  1  output stage holds a decoded instruction.
- orderType  out  7  decoded op code (package encoding).
- dec_rd, dec_rs1, dec_rs2  out  5 each  register indices; 0 when unused.
- dec_imm  out  32  sign- or zero-extended immediate.
- dec_pc  out  ADDR_WIDTH  instruction pc.
- dec_pred  out  1  prediction carried to rob.
- dec2lsb_en  out  1  dispatch fire to lsb (load/store).
- dec2rs_en  out  1  dispatch fire to rs (all other ops).
- dec2rob_en  out  1  dispatch fire to rob; equals dec2lsb_en | dec2rs_en.

Behaviour:
- Reset (async, rst_n_in=0): queue empty, pointers 0, every output 0 except dec_ready=1.
- Priority per edge: reset > !rdy_in (hold) > flush > normal.
- Flush: queue emptied, dec_valid=0, redirect=0; if_valid in that cycle ignored.
- Push: if_valid && dec_ready writes {pc, inst, pred} at tail.
- dec_ready = count < DEPTH, registered-count based. Push while full is ignored (no overwrite).
- Pointers are log2(DEPTH)+1 bits. Full/empty via MSB compare; wrap-around is natural.
- Fire (combinational):
  - is_mem = orderType[6:4] in {load, store};
  - fire = dec_valid && !robFull && (is_mem ? !lsbFull : !rsFull);
  - dec2lsb_en = fire & is_mem; dec2rs_en = fire & !is_mem.
- Output load: when queue non-empty and (!dec_valid || fire), head is decoded and registered, head pops, dec_valid=1. Otherwise dec_valid clears on fire and holds on stall; outputs stable while stalled.
- Latency: push at edge N -> dec_valid high after edge N+1 when the output stage is free. Throughput: 1 per cycle.
- Simultaneous push and pop: count unchanged. Push and pop to the same slot when count==1 is legal.
- Decode fields:
  - U-type: imm = {inst[31:12],12'b0}.
  - JAL: imm = J-imm.
  - JALR, I-type, load: imm = sign-extended inst[31:20]. JALR uses rs1. JALR does not redirect.
  - Shift-immediates: imm = {27'b0, inst[24:20]}; alt bit = inst[30].
  - sltiu: sign-extended immediate, compared unsigned.
  - Store: S-imm. Branch: B-imm.
  - R-type: alt bit = inst[30] for add/sub and srl/sra only.
- Redirect: when JAL, or a branch with pred=1, loads into the output stage:
  - redirect=1 for one cycle; redirect_pc = pc + imm (32-bit wrap);
  - on that same edge, all remaining queue entries are discarded and if_valid is ignored.
- Non-taken branches and other ops never redirect.

Optional Feature:
- DEC_ILLEGAL_CHECK_EN defined: unknown opcodes, bad funct3, and bad funct7 decode to package constant OP_ILLEGAL with rd=rs1=rs2=0. They dispatch to rs so the rob can trap; no redirect.
- Undefined: unknown encodings pass through as-is, with orderType built from opcode bits (no checking logic).

Decomposition:
- Package util.v holds:
  - opcode constants OP_LUI/AUIPC/JAL/JALR;
  - group codes OP_I_TYPE/R_TYPE/L_TYPE/S_TYPE/B_TYPE;
  - OP_ILLEGAL;
  - width macros ADDR_WIDTH/INST_WIDTH/REG_WIDTH/VAL_WIDTH/OP_WIDTH.
- One sub-module, rv32_decode_comb: purely combinational, inst -> {orderType, rd, rs1, rs2, imm}.
- decode_queue holds the queue, output register, fire and redirect logic.

Test Plan:
- Reset mid-burst: push 3 instructions, pulse rst_n_in low between edges -> queue empty, dec_valid=0, dec_ready=1 immediately (asynchronous).
- Fill with DEPTH=4, robFull=1: push 5 addi -> dec_ready=0 after 5 pushes (4 queued + 1 in the output stage); 6th push dropped. Release robFull -> all 5 fire in order, 1 per cycle.
- Backend routing: lw x5,8(x2) with lsbFull=1, rsFull=0 -> dec_valid held, no fire. Clear lsbFull -> dec2lsb_en=1, imm=8, rs1=2, rd=5.
- JAL at pc 0x100, imm +0x20, with 2 younger entries queued -> redirect=1, redirect_pc=0x120 for one cycle; the 2 entries are discarded.
- beq pred=0 -> no redirect. bne pred=1, imm -8, pc 0x40 -> redirect_pc=0x38.
- flush while dec_valid=1 and queue holds 3 -> next cycle dec_valid=0, empty. Same-cycle if_valid not stored. With rdy_in=0 the flush is ignored.
